// File: rtl/cacheline_burst_adaptor.sv
// Cacheline <-> memory burst adaptor.
// Turns one LINE_W-bit cache fill or writeback into a BEATS-long burst of
// BURST_W-bit beats on the memory port, and returns a one-cycle completion
// pulse to the cache. Writebacks win over fills when both are requested,
// because a dirty victim must leave before its replacement arrives.
module cacheline_burst_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    // cache side
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    // memory side
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_e;

    typedef logic [BEATS-1:0][BURST_W-1:0] line_t;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_inc;
    line_t              buf_q;
    line_t              line_out_q;
    line_t              fill_line;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  aligned_addr;
    logic [BURST_W-1:0] burst_q;
    logic               read_q;
    logic               write_q;
    logic               resp_q;

    assign aligned_addr = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign count_inc    = count_q + CNT_W'(1);

    // Fill line as it will look once the final beat on burst_i is merged in.
    always_comb begin
        // NOTE: assign the whole variable first so every path drives it and no latch is inferred.
        fill_line            = buf_q;
        fill_line[LAST_BEAT] = burst_i;
    end

    // Burst sequencer: request latching, beat counting and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            // NOTE: the line buffers are plain registers, not RAM, so clearing them on reset is cheap and keeps line_o defined.
            buf_q      <= '0;
            line_out_q <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            resp_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            unique case (state_q)
                IDLE: begin
                    count_q <= '0;
                    resp_q  <= 1'b0;
                    if (write_i) begin
                        addr_q  <= aligned_addr;
                        buf_q   <= line_i;
                        burst_q <= line_i[BURST_W-1:0];
                        write_q <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (read_i) begin
                        addr_q  <= aligned_addr;
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end

                RD_BURST: begin
                    if (resp_i) begin
                        buf_q[count_q] <= burst_i;
                        count_q        <= count_inc;
                        if (count_q == LAST_BEAT) begin
                            read_q     <= 1'b0;
                            line_out_q <= fill_line;
                            resp_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end

                WR_BURST: begin
                    if (resp_i) begin
                        count_q <= count_inc;
                        burst_q <= buf_q[count_inc];
                        if (count_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = line_out_q;
    assign resp_o    = resp_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: a cache-side driver plus a
// behavioural memory. Expected fill lines, completion values and write beats
// are queued when a request is issued and popped as the adaptor produces them.
module tb_cacheline_burst_adaptor;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned ADDR_W  = 32;

    logic              clk;
    logic              rst;
    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    cacheline_burst_adaptor #(
        .LINE_W (LINE_W),
        .BURST_W(BURST_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int resp_seen = 0;
    int resp_exp  = 0;

    logic [LINE_W-1:0]  cpl_q[$];   // expected line_o at each resp_o
    logic [BURST_W-1:0] beat_q[$];  // expected write beats in order
    logic [LINE_W-1:0]  model_line; // line_o as the cache should currently see it

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Cache-side request; queues expectations, then lets the adaptor sample it.
    task automatic request(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wline, input logic [LINE_W-1:0] rline);
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = wline;
        if (wr) begin
            for (int b = 0; b < 4; b++) beat_q.push_back(wline[b*64 +: 64]);
            cpl_q.push_back(model_line);
        end
        if (rd) begin
            cpl_q.push_back(rline);
            model_line = rline;
        end
        tick();
    endtask

    // Memory-side burst: pat[i] is resp_i in the i-th burst cycle.
    task automatic serve(input logic is_rd, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] mem_line,
                         input logic [15:0] pat, input int pat_len, input int drop_at, input logic keep_rd);
        int beat = 0;
        int t = 0;
        logic [LINE_W-1:0] exp_line;
        while (!(is_rd ? read_o : write_o) && t < 10) begin
            tick();
            t++;
        end
        check(is_rd ? "rd_start" : "wr_start", is_rd ? read_o : write_o, 1);
        if (!(is_rd ? read_o : write_o)) return;
        check("address_o", address_o, {addr[ADDR_W-1:5], 5'b0});
        for (int i = 0; i < pat_len; i++) begin
            if (i == drop_at) begin
                read_i  = 1'b0;
                write_i = 1'b0;
            end
            if (!keep_rd) begin
                address_i = $urandom;
                line_i    = {8{$urandom}};
            end
            check("req_held", is_rd ? read_o : write_o, 1);
            check("resp_early", resp_o, 0);
            resp_i  = pat[i];
            burst_i = is_rd ? mem_line[beat*64 +: 64] : {$urandom, $urandom};
            if (!is_rd && pat[i]) check("wr_beat", burst_o, beat_q.pop_front());
            if (pat[i]) beat++;
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        check("resp_pulse", resp_o, 1);
        check("req_drop", is_rd ? read_o : write_o, 0);
        exp_line = (cpl_q.size() > 0) ? cpl_q.pop_front() : '0;
        check("line_o", line_o, exp_line);
        resp_exp++;
        write_i = 1'b0;
        if (!keep_rd) read_i = 1'b0;
        tick();
        check("resp_width", resp_o, 0);
    endtask

    // Protocol watchers: request exclusivity and total completion pulses.
    always @(negedge clk) begin
        if (read_o && write_o) check("rw_exclusive", {read_o, write_o}, 2'b00);
        if (resp_o) resp_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] l1, w2, l3, w4, l4, w5, l6, l7;
        l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        w2 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        l3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_CAFE_F00D, 64'h0BAD_F00D_1234_5678};
        w4 = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        l4 = {64'hA4A4_A4A4_A4A4_A4A4, 64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1};
        w5 = {64'h5555_5555_0000_0004, 64'h5555_5555_0000_0003, 64'h5555_5555_0000_0002, 64'h5555_5555_0000_0001};
        l6 = {64'h6666_0000_6666_0004, 64'h6666_0000_6666_0003, 64'h6666_0000_6666_0002, 64'h6666_0000_6666_0001};
        l7 = {64'h7777_7777_7777_7004, 64'h7777_7777_7777_7003, 64'h7777_7777_7777_7002, 64'h7777_7777_7777_7001};

        rst        = 1'b0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        resp_i     = 1'b0;
        address_i  = '0;
        line_i     = '0;
        burst_i    = '0;
        model_line = '0;
        repeat (2) tick();
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_resp_o", resp_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_line_o", line_o, 0);
        rst = 1'b1;
        tick();

        // Memory chatter while idle must be ignored.
        resp_i  = 1'b1;
        burst_i = '1;
        repeat (2) tick();
        check("idle_resp_o", resp_o, 0);
        check("idle_line_o", line_o, 0);
        check("idle_read_o", read_o, 0);
        resp_i  = 1'b0;
        burst_i = '0;

        // Plain fill, back-to-back beats.
        request(1'b1, 1'b0, 32'h0000_1234, '0, l1);
        serve(1'b1, 32'h0000_1234, l1, 16'h000F, 4, 99, 1'b0);

        // Plain writeback; line_o must keep the previous fill.
        request(1'b0, 1'b1, 32'h8000_0047, w2, '0);
        serve(1'b0, 32'h8000_0047, '0, 16'h000F, 4, 99, 1'b0);

        // Fill with stalls: resp_i = 1,0,0,1,1,0,1.
        request(1'b1, 1'b0, 32'hCAFE_F01F, '0, l3);
        serve(1'b1, 32'hCAFE_F01F, l3, 16'h0059, 7, 99, 1'b0);

        // Dirty miss: write and read together -> writeback, then fill.
        request(1'b1, 1'b1, 32'h0000_ABE0, w4, l4);
        serve(1'b0, 32'h0000_ABE0, '0, 16'h000F, 4, 99, 1'b1);
        serve(1'b1, 32'h0000_ABE0, l4, 16'h001D, 5, 99, 1'b0);

        // Reset in the middle of a writeback, after two beats.
        request(1'b0, 1'b1, 32'h1357_9BDF, w5, '0);
        check("rst5_start", write_o, 1);
        for (int i = 0; i < 2; i++) begin
            check("rst5_beat", burst_o, beat_q.pop_front());
            resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        rst    = 1'b0;
        #1;
        check("mid_rst_read_o", read_o, 0);
        check("mid_rst_write_o", write_o, 0);
        check("mid_rst_resp_o", resp_o, 0);
        check("mid_rst_address_o", address_o, 0);
        check("mid_rst_burst_o", burst_o, 0);
        check("mid_rst_line_o", line_o, 0);
        write_i = 1'b0;
        beat_q.delete();
        void'(cpl_q.pop_back());
        model_line = '0;
        tick();
        check("mid_rst_no_resp", resp_o, 0);
        rst = 1'b1;
        tick();
        request(1'b1, 1'b0, 32'h2468_ACE0, '0, l6);
        serve(1'b1, 32'h2468_ACE0, l6, 16'h000F, 4, 99, 1'b0);

        // Request dropped after the first beat; burst still completes.
        request(1'b1, 1'b0, 32'h0F0F_0F3F, '0, l7);
        serve(1'b1, 32'h0F0F_0F3F, l7, 16'h000F, 4, 1, 1'b0);
        repeat (3) tick();
        check("idle_after_drop", read_o, 0);

        check("resp_count", resp_seen, resp_exp);
        check("cpl_q_empty", cpl_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Sits between the 4-way cache controller and physical memory.
- Converts one 256-bit cacheline read or writeback into a 4-beat, 64-bit memory burst.
- Returns a single-cycle completion pulse to the cache.
- Consumes the cache's pmem_read/pmem_write requests and drives the burst-oriented memory port.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits. LINE_W must be an integer multiple of BURST_W; BEATS = LINE_W/BURST_W = 4.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- line_i  in  LINE_W  writeback line from the cache data array.
- line_o  out  LINE_W  assembled fill line to the cache.
- address_i  in  ADDR_W  cache miss or writeback address.
- read_i  in  1  cache line-read request (pmem_read).
- write_i  in  1  cache line-write request (pmem_write).
- resp_o  out  1  line transfer complete; 1-cycle pulse.
- burst_i  in  BURST_W  memory read beat.
- burst_o  out  BURST_W  memory write beat.
- address_o  out  ADDR_W  line-aligned burst address.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat accepted/valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0.
  - read_o=0, write_o=0, resp_o=0.
  - address_o=0, burst_o=0, line_o=0, internal line buffer=0.
  - Reset asserted mid-burst aborts to IDLE with the same values; no resp_o is generated.
- All outputs are registered.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - On write_i=1: latch address_o={address_i[ADDR_W-1:5],5'b0}, latch line_i into the buffer, count=0, write_o<=1, burst_o<=line_i[63:0]; go to WR_BURST.
  - Else on read_i=1: latch the aligned address, count=0, read_o<=1; go to RD_BURST.
  - write_i has priority when both are high, because a dirty writeback precedes the fill.
- RD_BURST:
  - Each cycle resp_i=1: buffer[count*64 +: 64]<=burst_i, count++.
  - Beat 0 maps to bits 63:0 (little-endian beat order).
  - resp_i=0 cycles are stalls; nothing is captured and count holds.
  - On the 4th beat (count==3 and resp_i): read_o<=0, line_o<=assembled line including burst_i, resp_o<=1; go to DONE.
- WR_BURST:
  - write_o stays high and burst_o presents beat[count].
  - Each resp_i=1: count++ and burst_o<=next beat.
  - On the 4th beat: write_o<=0, resp_o<=1; go to DONE.
- DONE:
  - resp_o<=0; go to IDLE.
  - New requests are not sampled in DONE, which gives the cache one cycle to drop or change its request after resp_o.
- Latency:
  - Request sampled in cycle 0; read_o/write_o high from cycle 1.
  - With resp_i high every cycle from cycle 1, beats are taken in cycles 1–4 and resp_o is high in cycle 5.
- line_o holds its value from resp_o until the next completed read. Writes do not modify line_o.
- Request dropped mid-burst: the burst still runs to 4 beats, because the memory cannot abort, and resp_o still pulses.
- address_i and line_i changing mid-burst have no effect; they are latched in IDLE.
- resp_i high while in IDLE or DONE is ignored.
- count is 2 bits and wraps 3→0 only on state exit; it is reset to 0 in IDLE.
- read_o and write_o are never high simultaneously.

Test Plan:
- Reset, then read_i=1 with address_i=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → address_o=0x0000_1220; line_o=0x44..44_33..33_22..22_11..11; resp_o high exactly 1 cycle, in cycle 5; read_o low from cycle 5.
- write_i=1 with line_i={0xD..,0xC..,0xB..,0xA..} and resp_i held high 4 cycles → burst_o sequence A, B, C, D; write_o high for exactly 4 cycles; one resp_o pulse; line_o unchanged.
- Read with resp_i pattern 1,0,0,1,1,0,1 → 4 beats captured in order, stalls ignored; resp_o one cycle after the 7th pattern cycle.
- read_i and write_i both high in IDLE → write burst performed first; after DONE, with read_i still high, a read burst follows, giving the dirty-miss writeback-then-fill sequence.
- rst pulsed low after beat 2 of a write → all outputs 0 immediately (asynchronous), no resp_o; a subsequent read completes normally.
- read_i dropped after 1 beat → 3 remaining beats still accepted; resp_o pulses; FSM returns to IDLE.
